// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out transmitter. Accepts words over a valid/ready
//   handshake into a one-word holding register and shifts each word out
//   LSB-first on `so`. A held word is moved into the shifter on the same edge
//   the previous word's last bit retires, so consecutive words leave without
//   a gap and a downstream WIDTH-bit shift register sees each word intact.
//
// Ports
//   clk          clock, rising-edge
//   rst          asynchronous, active-high reset
//   load_valid   upstream offers load_data
//   load_data    [WIDTH] word to transmit
//   load_ready   holding register is empty (depends on state only)
//   so           registered serial data
//   so_valid     so carries a data bit this cycle
//   frame_start  so carries bit 0 of a word this cycle
//   busy         shifter active or holding register full
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic [WIDTH-1:0] sr_r;
    logic [CW-1:0]    cnt_r;
    logic             so_r;
    logic             so_valid_r;
    logic             frame_start_r;

    logic             accept_s;
    logic             xfer_s;
    logic [CW-1:0]    cnt_inc_s;

    // Accept and transfer are mutually exclusive: one needs an empty hold,
    // the other a full one.
    assign accept_s  = load_valid && !hold_full_r;
    assign xfer_s    = hold_full_r && ((state_r == IDLE) || (cnt_r == LAST));
    assign cnt_inc_s = cnt_r + CW'(1);

    assign load_ready  = !hold_full_r;
    assign busy        = (state_r == SHIFT) || hold_full_r;
    assign so          = so_r;
    assign so_valid    = so_valid_r;
    assign frame_start = frame_start_r;

    // Holding register, shifter and serial output state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            hold_r        <= '0;
            hold_full_r   <= 1'b0;
            sr_r          <= '0;
            cnt_r         <= '0;
            so_r          <= 1'b0;
            so_valid_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                hold_full_r <= 1'b0;
            end else if (accept_s) begin
                hold_r      <= load_data;
                hold_full_r <= 1'b1;
            end else begin
                hold_full_r <= hold_full_r;
            end

            if (xfer_s) begin
                // New word enters the shifter; bit 0 goes straight to so.
                state_r       <= SHIFT;
                sr_r          <= hold_r;
                cnt_r         <= '0;
                so_r          <= hold_r[0];
                so_valid_r    <= 1'b1;
                frame_start_r <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        so_r          <= 1'b0;
                        so_valid_r    <= 1'b0;
                        frame_start_r <= 1'b0;
                    end
                    SHIFT: begin
                        if (cnt_r != LAST) begin
                            cnt_r         <= cnt_inc_s;
                            so_r          <= sr_r[cnt_inc_s];
                            so_valid_r    <= 1'b1;
                            frame_start_r <= 1'b0;
                        end else begin
                            // Last bit retired with nothing held: go quiet.
                            state_r       <= IDLE;
                            so_r          <= 1'b0;
                            so_valid_r    <= 1'b0;
                            frame_start_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r       <= IDLE;
                        so_r          <= 1'b0;
                        so_valid_r    <= 1'b0;
                        frame_start_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Drives a WIDTH=4 and a WIDTH=8 serializer. A queue-level reference model
//   (held word + bits still to emit) predicts every output each cycle, a
//   downstream shift-register model rebuilds words from the serial line and
//   compares them with the accepted words in order, and a vector table pins
//   the single-word and back-to-back waveforms cycle by cycle.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       lv4, lv8;
    logic [3:0] ld4;
    logic [7:0] ld8;
    logic       rdy4, so4, sv4, fs4, bsy4;
    logic       rdy8, so8, sv8, fs8, bsy8;

    piso_serializer #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_data(ld4),
        .load_ready(rdy4), .so(so4), .so_valid(sv4),
        .frame_start(fs4), .busy(bsy4)
    );

    piso_serializer #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_data(ld8),
        .load_ready(rdy8), .so(so8), .so_valid(sv8),
        .frame_start(fs8), .busy(bsy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          held [2];
    logic [31:0] hword[2];
    logic [31:0] fw   [2];   // current word, already shifted by bits emitted
    int          rem  [2];   // bits of current word still on/awaiting the line
    bit          fs_e [2];
    logic [31:0] aq0[$];
    logic [31:0] aq1[$];
    // downstream capture register model
    logic [31:0] sp[2];
    int          nb[2];
    logic [31:0] last_word[2];
    logic        p_so[2], p_sv[2], p_fs[2];

    function automatic int wid(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            held[i] = 0; hword[i] = 0; fw[i] = 0; rem[i] = 0; fs_e[i] = 0;
            sp[i] = 0; nb[i] = 0; p_so[i] = 0; p_sv[i] = 0; p_fs[i] = 0;
        end
        aq0.delete();
        aq1.delete();
    endtask

    task automatic model_edge(input int i, input logic v, input logic [31:0] d);
        bit acc;
        int w;
        w = wid(i);
        acc = v && !held[i];
        fs_e[i] = 0;
        if (rem[i] > 0) begin
            fw[i] = fw[i] >> 1;
            rem[i]--;
        end
        if (held[i] && rem[i] == 0) begin
            fw[i] = hword[i]; rem[i] = w; held[i] = 0; fs_e[i] = 1;
        end
        if (acc) begin
            hword[i] = d & ((32'h1 << w) - 32'h1);
            held[i]  = 1;
            if (i == 0) aq0.push_back(hword[i]); else aq1.push_back(hword[i]);
        end
    endtask

    task automatic sipo_edge(input int i);
        logic [31:0] e;
        int w;
        w = wid(i);
        if (p_sv[i]) begin
            if (p_fs[i]) begin
                sp[i] = 0; nb[i] = 0;
            end
            sp[i] = (sp[i] >> 1) | (32'(p_so[i]) << (w - 1));
            nb[i]++;
            if (nb[i] == w) begin
                if (i == 0 && aq0.size() > 0) e = aq0.pop_front();
                else if (i == 1 && aq1.size() > 0) e = aq1.pop_front();
                else e = 32'hDEAD_BEEF;
                chk($sformatf("w%0d_word", w), sp[i], e);
                last_word[i] = sp[i];
                nb[i] = 0;
            end
        end
    endtask

    task automatic compare_inst(input int i, input logic so_a, input logic sv_a,
                                input logic fs_a, input logic rdy_a, input logic bsy_a);
        int w;
        w = wid(i);
        chk($sformatf("w%0d_so", w), 32'(so_a), (rem[i] > 0) ? (fw[i] & 32'h1) : 32'h0);
        chk($sformatf("w%0d_so_valid", w), 32'(sv_a), 32'(rem[i] > 0));
        chk($sformatf("w%0d_frame_start", w), 32'(fs_a), 32'(fs_e[i]));
        chk($sformatf("w%0d_load_ready", w), 32'(rdy_a), 32'(!held[i]));
        chk($sformatf("w%0d_busy", w), 32'(bsy_a), 32'((rem[i] > 0) || held[i]));
    endtask

    // One clock: model sees pre-edge inputs, outputs checked 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge(0, lv4, 32'(ld4));
        model_edge(1, lv8, 32'(ld8));
        sipo_edge(0);
        sipo_edge(1);
        #1;
        compare_inst(0, so4, sv4, fs4, rdy4, bsy4);
        compare_inst(1, so8, sv8, fs8, rdy8, bsy8);
        p_so[0] = so4; p_sv[0] = sv4; p_fs[0] = fs4;
        p_so[1] = so8; p_sv[1] = sv8; p_fs[1] = fs8;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_so4"}, 32'(so4), 32'h0);
        chk({tag, "_sv4"}, 32'(sv4), 32'h0);
        chk({tag, "_fs4"}, 32'(fs4), 32'h0);
        chk({tag, "_busy4"}, 32'(bsy4), 32'h0);
        chk({tag, "_ready4"}, 32'(rdy4), 32'h1);
        chk({tag, "_sv8"}, 32'(sv8), 32'h0);
        chk({tag, "_ready8"}, 32'(rdy8), 32'h1);
    endtask

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       so, sv, fs, rdy;
    } vec_t;

    vec_t tbl[20];

    task automatic row(input int k, input logic v, input logic [3:0] d,
                       input logic so_e, input logic sv_e, input logic fs_e_, input logic rdy_e);
        tbl[k].v = v; tbl[k].d = d; tbl[k].so = so_e;
        tbl[k].sv = sv_e; tbl[k].fs = fs_e_; tbl[k].rdy = rdy_e;
    endtask

    initial begin
        logic [7:0] c5;
        bit acc, got80;
        int cnt_v, first_v, last_v;

        // single word 4'b1011
        row(0,  1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
        row(1,  1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        row(2,  1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        row(3,  1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        row(4,  1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        row(5,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        // back-to-back A,5,3 with valid held high
        row(6,  1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        row(7,  1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1);
        row(8,  1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        row(9,  1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        row(10, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        row(11, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1);
        row(12, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        row(13, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        row(14, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        row(15, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        row(16, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        row(17, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        row(18, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        row(19, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        rst = 1'b1; lv4 = 1'b0; ld4 = 4'h0; lv8 = 1'b0; ld8 = 8'h0;
        last_word[0] = 0; last_word[1] = 0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        #4 rst = 1'b0;

        // ---- vector table ----
        for (int k = 0; k < 20; k++) begin
            lv4 = tbl[k].v; ld4 = tbl[k].d;
            step();
            chk($sformatf("tbl%0d_so", k), 32'(so4), 32'(tbl[k].so));
            chk($sformatf("tbl%0d_sv", k), 32'(sv4), 32'(tbl[k].sv));
            chk($sformatf("tbl%0d_fs", k), 32'(fs4), 32'(tbl[k].fs));
            chk($sformatf("tbl%0d_ready", k), 32'(rdy4), 32'(tbl[k].rdy));
            if (k == 5) chk("single_po", last_word[0], 32'hB);
        end
        chk("btb_last_po", last_word[0], 32'h3);

        // ---- backpressure: 6 shifting, 9 held, F offered ----
        lv4 = 1'b1; ld4 = 4'h6; step();
        ld4 = 4'h9; step(); step();
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            if (rdy4) ld4 = 4'hF;
            else ld4 = 4'($urandom);
            acc = rdy4;
            step();
        end
        chk("bp_accepted", 32'(acc), 32'h1);
        lv4 = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("bp_word_F", last_word[0], 32'hF);

        // ---- reset mid-word: 4'b1100 shifting, 7 held ----
        lv4 = 1'b1; ld4 = 4'hC; step();
        ld4 = 4'h7; step(); step();
        lv4 = 1'b0;
        #3 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        model_reset();
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) step();
        lv4 = 1'b1; ld4 = 4'h9; step();
        lv4 = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("after_rst_word", last_word[0], 32'h9);

        // ---- WIDTH=8: 8'hC5 ----
        c5 = 8'hC5;
        lv8 = 1'b1; ld8 = c5; step();
        lv8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("c5_bit%0d", k), 32'(so8), 32'(c5[k]));
        end
        step();
        chk("c5_end_sv", 32'(sv8), 32'h0);
        chk("c5_po", last_word[1], 32'hC5);

        // ---- WIDTH=8: 01 then 80 gap-free ----
        lv8 = 1'b1; ld8 = 8'h01; step();
        ld8 = 8'h80; got80 = 1'b0;
        cnt_v = 0; first_v = -1; last_v = -1;
        for (int k = 0; k < 24; k++) begin
            acc = lv8 && rdy8;
            step();
            if (acc) got80 = 1'b1;
            lv8 = !got80;
            if (sv8) begin
                cnt_v++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
        end
        chk("stream_bits", 32'(cnt_v), 32'd16);
        chk("stream_span", 32'(last_v - first_v + 1), 32'd16);
        chk("stream_po", last_word[1], 32'h80);

        // ---- randomized traffic on both widths ----
        for (int k = 0; k < 400; k++) begin
            lv4 = ($urandom_range(0, 3) != 0);
            ld4 = 4'($urandom);
            lv8 = ($urandom_range(0, 2) != 0);
            ld8 = 8'($urandom);
            step();
        end
        lv4 = 1'b0; lv8 = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("drain4", 32'(aq0.size()), 32'h0);
        chk("drain8", 32'(aq1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
